// File: rtl/polydiv_8bit_seq.sv
// polydiv_8bit_seq: sequential carry-less (GF(2)[x]) division of a 15-bit dividend by an 8-bit divisor.
// It consumes one dividend bit per cycle. The optional macro POLYDIV_DIVZERO_EN enables divide-by-zero flagging.
`default_nettype none

module polydiv_8bit_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] quotient,
    output logic [7:0]  remainder,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_STEP = 4'd14;

    state_t      r_state;
    state_t      w_state_nx;

    logic [14:0] r_dvd;
    logic [7:0]  r_dvs;
    logic [2:0]  r_deg;
    logic [7:0]  r_rem;
    logic [14:0] r_q;
    logic [3:0]  r_cnt;

    logic        w_accept;
    logic        w_divzero;
    logic        w_dz_skip;
    logic [2:0]  w_deg_in;
    logic [7:0]  w_rem_sh;
    logic        w_qbit;
    logic [7:0]  w_rem_nx;
    logic        w_done;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_divzero = (divisor == 8'd0);
    assign w_done    = (r_state == ST_DONE);

    // Priority encode: highest set divisor bit wins; an all-zero divisor yields 0.
    always_comb begin
        w_deg_in = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (divisor[i]) begin
                w_deg_in = i[2:0];
            end
        end
    end

    // One long-division step; the zero-divisor guard keeps a zero divisor from producing quotient bits.
    assign w_rem_sh = {r_rem[6:0], r_dvd[14]};
    assign w_qbit   = w_rem_sh[r_deg] & (|r_dvs);
    assign w_rem_nx = w_qbit ? (w_rem_sh ^ r_dvs) : w_rem_sh;

`ifdef POLYDIV_DIVZERO_EN
    logic r_err;

    assign w_dz_skip = w_divzero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_divzero;
        end
    end

    assign err = w_done & r_err;
`else
    assign w_dz_skip = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nx = w_dz_skip ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == C_LAST_STEP) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dvd <= 15'd0;
            r_dvs <= 8'd0;
            r_deg <= 3'd0;
            r_rem <= 8'd0;
            r_q   <= 15'd0;
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_deg <= w_deg_in;
            r_rem <= 8'd0;
            r_q   <= 15'd0;
            r_cnt <= 4'd0;
        end else if (r_state == ST_BUSY) begin
            r_dvd <= {r_dvd[13:0], 1'b0};
            r_rem <= w_rem_nx;
            r_q   <= {r_q[13:0], w_qbit};
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = w_done;
    assign quotient  = w_done ? r_q   : 15'd0;
    assign remainder = w_done ? r_rem : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_polydiv_8bit_seq.sv
// Directed, table-driven bench for polydiv_8bit_seq.
`default_nettype none

module tb_polydiv_8bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] quotient;
    logic [7:0]  remainder;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    polydiv_8bit_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  b;
        logic [14:0] q;
        logic [7:0]  r;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Issue one request from IDLE, return result and latency (cycles from accept cycle to first out_valid).
    task automatic do_op(input logic [14:0] a, input logic [7:0] b,
                         output logic [14:0] q, output logic [7:0] r,
                         output logic e, output int lat);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 15'h5A5A;
        divisor  = 8'hA5;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        e = err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [14:0] q, q0;
        logic [7:0]  r, r0;
        logic        e, e0;
        int          lat;
        bit          stable, busy_flag, leak;

        vt[0] = '{15'h2B79, 8'h83, 15'h0057, 8'h00, 1'b0, 16};
        vt[1] = '{15'h0011, 8'h03, 15'h000F, 8'h00, 1'b0, 16};
        vt[2] = '{15'h7FFF, 8'h01, 15'h7FFF, 8'h00, 1'b0, 16};
        vt[3] = '{15'h0005, 8'h08, 15'h0000, 8'h05, 1'b0, 16};
        vt[4] = '{15'h0100, 8'h11, 15'h0011, 8'h01, 1'b0, 16};
        vt[5] = '{15'h7FFF, 8'h80, 15'h00FF, 8'h7F, 1'b0, 16};
        vt[6] = '{15'h0003, 8'h03, 15'h0001, 8'h00, 1'b0, 16};
        vt[7] = '{15'h000F, 8'h02, 15'h0007, 8'h01, 1'b0, 16};
`ifdef POLYDIV_DIVZERO_EN
        vt[8] = '{15'h1234, 8'h00, 15'h0000, 8'h00, 1'b1, 1};
`else
        vt[8] = '{15'h1234, 8'h00, 15'h0000, 8'h34, 1'b0, 16};
`endif
        vt[9] = '{15'h0000, 8'hFF, 15'h0000, 8'h00, 1'b0, 16};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 15'd0;
        divisor   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset outputs", {8'd0, err, remainder, quotient}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_op(vt[i].a, vt[i].b, q, r, e, lat);
            chk($sformatf("v%0d quotient", i), 32'(q), 32'(vt[i].q));
            chk($sformatf("v%0d remainder", i), 32'(r), 32'(vt[i].r));
            chk($sformatf("v%0d err", i), 32'(e), 32'(vt[i].e));
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d idle after", i), {in_ready, out_valid, 6'd0, err, remainder, quotient},
                32'h8000_0000);
        end

        // Backpressure in DONE, then a back-to-back request held from the return to IDLE.
        dividend = 15'h2B79;
        divisor  = 8'h83;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp latency", 32'(lat), 32'd16);
        q0 = quotient;
        r0 = remainder;
        e0 = err;
        stable    = 1'b1;
        busy_flag = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!out_valid || quotient !== q0 || remainder !== r0 || err !== e0) stable = 1'b0;
            if (in_ready !== 1'b0) busy_flag = 1'b0;
        end
        chk("bp held quotient", 32'(q0), 32'h0057);
        chk("bp outputs stable", 32'(stable), 32'd1);
        chk("bp in_ready low", 32'(busy_flag), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 15'h0011;
        divisor   = 8'h03;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release idle", {30'd0, in_ready, out_valid}, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b accepted", 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b latency", 32'(lat), 32'd16);
        chk("b2b result", {9'd0, remainder, quotient}, {9'd0, 8'h00, 15'h000F});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset at BUSY step 7 aborts the operation with no result.
        dividend = 15'h2B79;
        divisor  = 8'h83;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort idle", {in_ready, out_valid, 6'd0, err, remainder, quotient}, 32'h8000_0000);
        leak = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) leak = 1'b1;
        end
        chk("abort no result", 32'(leak), 32'd0);
        do_op(15'h0100, 8'h11, q, r, e, lat);
        chk("post-abort result", {9'd0, r, q}, {9'd0, 8'h01, 15'h0011});
        chk("post-abort latency", 32'(lat), 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
